// File: rtl/cipher_iv_bank_if.sv
// cipher_iv_bank_if: host/core signal bundle for the IV/chaining register bank
interface cipher_iv_bank_if #(
  parameter int DW  = 32,
  parameter int NW  = 2,
  parameter int NCH = 2
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  logic              clrptr_n;
  logic              lock;
  logic [CW-1:0]     ch_sel;
  logic              wr;
  logic [DW-1:0]     wdata;
  logic              rd;
  logic [DW-1:0]     rdata;
  logic              full;
  logic              ovf;
  logic              upd;
  logic [CW-1:0]     core_ch;
  logic [NW*DW-1:0]  upd_data;
  logic [NW*DW-1:0]  iv_out;
  logic              iv_vld;
  logic              upd_lost;
  modport master (
    output clrptr_n, lock, ch_sel, wr, wdata, rd, upd, core_ch, upd_data,
    input  rdata, full, ovf, iv_out, iv_vld, upd_lost
  );
  modport slave (
    input  clrptr_n, lock, ch_sel, wr, wdata, rd, upd, core_ch, upd_data,
    output rdata, full, ovf, iv_out, iv_vld, upd_lost
  );
endinterface

// File: rtl/cipher_iv_bank.sv
// cipher_iv_bank: multi-channel IV/chaining bank, host word loads and core block updates
module cipher_iv_bank #(
  parameter int DW  = 32,
  parameter int NW  = 2,
  parameter int NCH = 2
) (
  input  logic                hclk,
  input  logic                hresetn,
  cipher_iv_bank_if.slave     io_bus
);
  localparam int PW = $clog2(NW + 1);
  localparam int AW = $clog2(NW);
  localparam logic [PW-1:0] FULL_P = PW'(NW);
  localparam logic [AW-1:0] LAST_R = AW'(NW - 1);

  logic [DW-1:0] r_mem  [NCH][NW];
  logic [PW-1:0] r_wptr [NCH];
  logic [AW-1:0] r_rptr [NCH];
  logic [NCH-1:0] r_vld;
  logic          r_ovf;
  logic          r_upd_lost;

  logic [PW-1:0] w_wptr;
  logic [AW-1:0] w_widx;
  logic          w_hwr_try;
  logic          w_hwr;
  logic          w_hovf;
  logic          w_coll;
  logic          w_upd;

  always_comb begin
    w_wptr    = r_wptr[io_bus.ch_sel];
    w_widx    = w_wptr[AW-1:0];
    w_hwr_try = io_bus.wr & ~io_bus.lock;
    w_hwr     = w_hwr_try & (w_wptr != FULL_P);
    w_hovf    = w_hwr_try & (w_wptr == FULL_P);
    w_coll    = io_bus.upd & w_hwr & (io_bus.core_ch == io_bus.ch_sel);
    w_upd     = io_bus.upd & ~w_coll;
  end

  // Memory writes proceed even during clrptr_n; only pointers and flags are cleared.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < NW; k++) r_mem[c][k] <= '0;
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
      end
      r_vld      <= '0;
      r_ovf      <= 1'b0;
      r_upd_lost <= 1'b0;
    end else begin
      if (w_upd)
        for (int k = 0; k < NW; k++) r_mem[io_bus.core_ch][k] <= io_bus.upd_data[k*DW +: DW];
      if (w_hwr) r_mem[io_bus.ch_sel][w_widx] <= io_bus.wdata;
      if (!io_bus.clrptr_n) begin
        for (int c = 0; c < NCH; c++) begin
          r_wptr[c] <= '0;
          r_rptr[c] <= '0;
        end
        r_vld      <= '0;
        r_ovf      <= 1'b0;
        r_upd_lost <= 1'b0;
      end else begin
        r_upd_lost <= w_coll;
        if (w_hovf) r_ovf <= 1'b1;
        if (w_upd) r_vld[io_bus.core_ch] <= 1'b1;
        if (w_hwr) begin
          r_wptr[io_bus.ch_sel] <= w_wptr + 1'b1;
          if (w_wptr + 1'b1 == FULL_P) r_vld[io_bus.ch_sel] <= 1'b1;
        end
        if (io_bus.rd)
          r_rptr[io_bus.ch_sel] <= (r_rptr[io_bus.ch_sel] == LAST_R) ? '0 : r_rptr[io_bus.ch_sel] + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NW; k++) begin : g_iv
    assign io_bus.iv_out[k*DW +: DW] = r_mem[io_bus.core_ch][k];
  end

  assign io_bus.rdata    = r_mem[io_bus.ch_sel][r_rptr[io_bus.ch_sel]];
  assign io_bus.full     = w_wptr == FULL_P;
  assign io_bus.ovf      = r_ovf;
  assign io_bus.iv_vld   = r_vld[io_bus.core_ch];
  assign io_bus.upd_lost = r_upd_lost;
endmodule

// File: doc/cipher_iv_bank.md
# cipher_iv_bank

Parametrised multi-channel initialisation-vector / chaining register bank for the block-cipher datapath (DES, 3DES, AES). The host loads each channel's IV one bus word at a time; the cipher core overwrites a whole channel in one cycle with its chaining value. The bank presents the selected channel's full vector to the core. It replaces the fixed two-word, single-channel DES IV register and adds the following:
- channel contexts
- word-wise readback
- overflow detection
- load-complete status
- a lock

## Interface
- DW, 32, bus word width in bits.
- NW, 2, words per cipher block. Use 2 for DES and 4 for AES; must be ≥2.
- NCH, 2, number of IV channels (contexts); must be ≥1.
- CW, max(1,clog2(NCH)), channel-select width (derived).
- PW, clog2(NW+1), pointer width (derived).

Ports:
- hclk  in  1  clock; all state updates on rising edge.
- hresetn  in  1  reset, asynchronous, active-low.
- clrptr_n  in  1  synchronous active-low clear of all pointers and status flags; memory untouched.
- lock  in  1  1 = host writes ignored (core updates still allowed).
- ch_sel  in  CW  host-side channel for wr/rd/status.
- wr  in  1  host word-write strobe, one word per cycle.
- wdata  in  DW  host write word.
- rd  in  1  host read-advance strobe.
- rdata  out  DW  word at ch_sel's read pointer (combinational).
- full  out  1  ch_sel's write pointer == NW.
- ovf  out  1  sticky: host write attempted to a full channel.
- upd  in  1  core bulk-update strobe.
- core_ch  in  CW  core-side channel for upd and iv_out.
- upd_data  in  NW*DW  chaining value; word k = bits [k*DW+DW-1 : k*DW].
- iv_out  out  NW*DW  full vector of core_ch (combinational from storage).
- iv_vld  out  1  core_ch has been fully host-loaded or core-updated since last clear.
- upd_lost  out  1  one-cycle pulse: upd dropped due to collision.

## Operation
- Storage: mem[ch][k], NCH×NW words of DW bits. Per channel:
  - wptr (0..NW)
  - rptr (0..NW-1)
  - vld bit
- Host write: wr=1, lock=0, wptr[ch_sel]<NW, then:
  - mem[ch_sel][wptr] ← wdata
  - wptr++
  - if the new wptr==NW, vld[ch_sel] ← 1
- Write to full channel: wr=1, lock=0, wptr==NW. Memory and pointer unchanged; ovf ← 1, which stays set until clrptr_n or reset.
- Locked write: wr=1 with lock=1 is ignored completely, with no ovf.
- Host read: rdata = mem[ch_sel][rptr[ch_sel]]. rd=1 advances rptr, wrapping from NW-1 to 0. rd and wr in the same cycle are independent.
- Core update: upd=1 writes all NW words of mem[core_ch] from upd_data and sets vld[core_ch]. Pointers are not modified.
- Collision: upd=1, an effective host write, and core_ch==ch_sel in the same cycle.
  - The host write takes effect.
  - The entire upd is discarded.
  - upd_lost=1 on the next cycle for one cycle.
- Different channels: the host write and upd both complete in the same cycle.
- clrptr_n=0 forces, for every channel, wptr=0, rptr=0, vld=0, ovf=0. It has priority over wr/rd/upd in that cycle: memory writes are still performed, flag and pointer updates are discarded.
- Word-width/order: host word 0 is the least-significant word of iv_out. Widths are exact; no truncation or sign handling.

## Timing
- Reset (hresetn=0, async): all mem=0, all pointers=0, vld=0, ovf=0, upd_lost=0. Resulting output values: rdata=0, iv_out=0, full=0, iv_vld=0.
- Write latency: a wr or upd on edge N is visible on rdata/iv_out/full/iv_vld after edge N (combinational from registers).
- Outputs follow ch_sel/core_ch changes combinationally, in the same cycle.
- Reset asserted mid-load returns all state to reset values immediately; the partial load is lost.
- Throughput: one host word per cycle plus one full-block update per cycle.

## Test plan
- Reset, NW=2, NCH=2: expect iv_out=0, full=0, iv_vld=0, ovf=0. Write 0x11111111 then 0x22222222 to ch0: expect iv_out(core_ch=0)=0x22222222_11111111, full=1, iv_vld=1.
- Overflow: third wr of 0x33333333 to full ch0 gives ovf=1 with iv_out unchanged. clrptr_n pulse then gives ovf=0, full=0; the memory still holds 0x22222222_11111111.
- Readback: with ch0 loaded, rd three times; rdata sequence is 0x11111111, 0x22222222, 0x11111111 (wrap).
- Core update: upd with core_ch=1, upd_data=0xAAAA5555_DEADBEEF gives iv_out(core_ch=1)=0xAAAA5555_DEADBEEF, iv_vld=1; ch0 unchanged.
- Collision: wr 0x12345678 to ch1 plus upd to ch1 in the same cycle. Expect mem[1][wptr]=0x12345678, the upd words absent, upd_lost pulse for 1 cycle. Repeat with core_ch=0: both complete, no upd_lost.
- Lock and async reset:
  - lock=1 with wr gives no change and no ovf.
  - hresetn asserted between word writes clears all state in the same cycle; the next write lands at word 0.
